// File: rtl/display_scan_ctrl.sv
// Multiplexed 8-digit 7-segment scanner: per-slot blank gap, PWM brightness window,
// and a shadow digit bank that is copied to the displayed bank only at a frame boundary.
module display_scan_ctrl #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int REFRESH_HZ   = 1000,
  parameter int NUM_DIGITS   = 8,
  parameter int BLANK_CYCLES = 200
) (
  input  logic       CLK_100MHZ,
  input  logic       RST_N,
  input  logic       WR_EN,
  input  logic [2:0] WR_ADDR,
  input  logic [5:0] WR_DATA,
  input  logic       COMMIT,
  input  logic [2:0] BRIGHT,
  output logic       COMMIT_PENDING,
  output logic       FRAME_TICK,
  output logic [7:0] AN,
  output logic [6:0] SEG,
  output logic       DP
);
  localparam int SLOT   = CLK_HZ / REFRESH_HZ;
  localparam int ON     = SLOT - BLANK_CYCLES;
  localparam int CNT_W  = (SLOT > 2) ? $clog2(SLOT) : 1;
  localparam int DUTY_W = CNT_W + 4;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON - 1);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_ON    = 1'b1;

  if (ON < 8) begin : g_on_check
    $error("display_scan_ctrl: ON window (SLOT - BLANK_CYCLES) must be at least 8 cycles");
  end
  if (BLANK_CYCLES < 1) begin : g_blank_check
    $error("display_scan_ctrl: BLANK_CYCLES must be at least 1");
  end
  if (NUM_DIGITS != 8) begin : g_digits_check
    $error("display_scan_ctrl: only 8 digits are supported");
  end

  logic [0:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        idx;
  logic [2:0]        bright_q;
  logic              pending;
  logic [5:0]        shadow [8];
  logic [5:0]        active [8];

  logic              slot_start;
  logic              frame_start;
  logic              do_copy;
  logic [DUTY_W-1:0] bright_plus1;
  logic [DUTY_W-1:0] duty_prod;
  logic [DUTY_W-1:0] duty;
  logic [5:0]        cur;
  logic              lit;
  logic [7:0]        an_p0;
  logic [6:0]        seg_p0;
  logic              dp_p0;

  function automatic logic [6:0] seg_decode(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign slot_start  = (state == ST_BLANK) && (cnt == '0);
  assign frame_start = slot_start && (idx == 3'd0);
  assign do_copy     = frame_start && pending;

  // Brightness window: DUTY = ((BRIGHT+1)*ON)>>3 using the value latched at slot start.
  assign bright_plus1 = DUTY_W'(bright_q) + DUTY_W'(1);
  assign duty_prod    = bright_plus1 * DUTY_W'(ON);
  assign duty         = duty_prod >> 3;

  assign cur    = active[idx];
  assign lit    = (state == ST_ON) && cur[5] && (DUTY_W'(cnt) < duty);
  assign an_p0  = lit ? ~(8'b1 << idx) : 8'hFF;
  assign seg_p0 = lit ? seg_decode(cur[3:0]) : 7'h7F;
  assign dp_p0  = lit ? ~cur[4] : 1'b1;

  always_ff @(posedge CLK_100MHZ or negedge RST_N) begin
    if (!RST_N) begin
      state    <= ST_BLANK;
      cnt      <= '0;
      idx      <= 3'd0;
      bright_q <= 3'd0;
    end else begin
      if (slot_start) bright_q <= BRIGHT;
      case (state)
        ST_BLANK: begin
          if (cnt == BLANK_LAST) begin
            state <= ST_ON;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (cnt == ON_LAST) begin
            state <= ST_BLANK;
            cnt   <= '0;
            idx   <= (idx == 3'd7) ? 3'd0 : idx + 3'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // The copy takes the pre-edge shadow, so a write on the copy edge lands in the next commit.
  always_ff @(posedge CLK_100MHZ or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < 8; i++) begin
        shadow[i] <= 6'd0;
        active[i] <= 6'd0;
      end
      pending <= 1'b0;
    end else begin
      if (do_copy) begin
        for (int i = 0; i < 8; i++) active[i] <= shadow[i];
      end
      if (WR_EN) shadow[WR_ADDR] <= WR_DATA;
      if (COMMIT)       pending <= 1'b1;
      else if (do_copy) pending <= 1'b0;
    end
  end

  // Registered output stage
  always_ff @(posedge CLK_100MHZ or negedge RST_N) begin
    if (!RST_N) begin
      AN         <= 8'hFF;
      SEG        <= 7'h7F;
      DP         <= 1'b1;
      FRAME_TICK <= 1'b0;
    end else begin
      AN         <= an_p0;
      SEG        <= seg_p0;
      DP         <= dp_p0;
      FRAME_TICK <= frame_start;
    end
  end

  assign COMMIT_PENDING = pending;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: cycle-position reference model plus directed scenarios.
module tb_display_scan_ctrl;
  localparam int SLOT  = 10;
  localparam int BLANK = 2;
  localparam int ON    = SLOT - BLANK;
  localparam int FRAME = 8 * SLOT;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [5:0] wr_data;
  logic       commit;
  logic [2:0] bright;
  logic       cp;
  logic       ft;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;

  always #5 clk = ~clk;

  display_scan_ctrl #(
    .CLK_HZ(1000), .REFRESH_HZ(100), .NUM_DIGITS(8), .BLANK_CYCLES(BLANK)
  ) dut (
    .CLK_100MHZ(clk), .RST_N(rst_n), .WR_EN(wr_en), .WR_ADDR(wr_addr),
    .WR_DATA(wr_data), .COMMIT(commit), .BRIGHT(bright),
    .COMMIT_PENDING(cp), .FRAME_TICK(ft), .AN(an), .SEG(seg), .DP(dp)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the display position is simply (edges since reset - 1) mod FRAME.
  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [5:0] m_shadow [8];
  logic [5:0] m_active [8];
  logic       m_pend;
  logic [2:0] m_bright;
  int         m_k;
  int         m_pos;
  logic [7:0] m_an;
  logic [6:0] m_seg;
  logic       m_dp;
  logic       m_ft;

  task automatic m_reset();
    for (int i = 0; i < 8; i++) begin
      m_shadow[i] = 6'd0;
      m_active[i] = 6'd0;
    end
    m_pend = 1'b0; m_bright = 3'd0; m_k = 0; m_pos = 0;
    m_an = 8'hFF; m_seg = 7'h7F; m_dp = 1'b1; m_ft = 1'b0;
  endtask

  task automatic m_step();
    int   slot, off, duty;
    logic copy, on;
    m_k++;
    m_pos = (m_k - 1) % FRAME;
    slot  = m_pos / SLOT;
    off   = m_pos % SLOT;
    copy  = (m_pos == 0) && m_pend;
    if (copy) for (int i = 0; i < 8; i++) m_active[i] = m_shadow[i];
    m_pend = commit ? 1'b1 : (copy ? 1'b0 : m_pend);
    if (wr_en) m_shadow[wr_addr] = wr_data;
    if (off == 0) m_bright = bright;
    duty  = ((int'(m_bright) + 1) * ON) >> 3;
    m_ft  = (m_pos == 0);
    on    = (off >= BLANK) && ((off - BLANK) < duty) && m_active[slot][5];
    m_an  = on ? ~(8'b1 << slot) : 8'hFF;
    m_seg = on ? hex_tab[m_active[slot][3:0]] : 7'h7F;
    m_dp  = on ? ~m_active[slot][4] : 1'b1;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else        m_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("AN", an, m_an);
      chk("SEG", seg, m_seg);
      chk("DP", dp, m_dp);
      chk("FRAME_TICK", ft, m_ft);
      chk("COMMIT_PENDING", cp, m_pend);
      chk("AN_onehot", ($countones(~an) <= 1), 1);
      if (rst_n && m_k > 0 && (m_pos % SLOT) < BLANK) chk("AN_blank", an, 8'hFF);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before timeout");
    $fatal(1, "watchdog");
  end

  task automatic wait_ft(input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while (ft !== 1'b1 && n < 200);
    chk(nm, ft, 1);
  endtask

  task automatic wait_an(input logic [7:0] v, input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while (an !== v && n < 200);
    chk(nm, an, v);
  endtask

  task automatic wait_pos(input int p, input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while (!(m_k > 0 && m_pos == p) && n < 200);
    chk(nm, m_pos, p);
  endtask

  task automatic wr(input logic [2:0] a, input logic [5:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
  endtask

  int bv [3] = '{7, 3, 0};
  int ev [3] = '{8, 4, 1};

  initial begin
    int last, cyc, lit_n, drops, n, on_n, first;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 6'd0; commit = 1'b0; bright = 3'd7;
    repeat (3) @(negedge clk);
    chk("rst_AN", an, 8'hFF);
    chk("rst_SEG", seg, 7'h7F);
    chk("rst_DP", dp, 1);
    chk("rst_TICK", ft, 0);
    chk("rst_PEND", cp, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_tick", ft, 1);

    // 1: dark display for 3 frames, ticks every 80 cycles
    last = 0; cyc = 0; lit_n = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk); cyc++;
      if (an !== 8'hFF) lit_n++;
      if (ft === 1'b1) begin
        chk("tick_period", cyc - last, 80);
        last = cyc;
      end
    end
    chk("t1_dark", lit_n, 0);

    // 2: write two digits and commit
    wr(3'd0, 6'h3A);
    wr(3'd1, 6'h21);
    pulse_commit();
    chk("t2_pending_set", cp, 1);
    drops = 0; n = 0;
    do begin
      @(negedge clk); n++;
      if (ft !== 1'b1 && cp !== 1'b1) drops++;
    end while (ft !== 1'b1 && n < 200);
    chk("t2_tick", ft, 1);
    chk("t2_pending_held", drops, 0);
    chk("t2_pending_cleared", cp, 0);
    wait_an(8'hFE, "t2_slot0_AN");
    chk("t2_slot0_SEG", seg, 7'h08);
    chk("t2_slot0_DP", dp, 0);
    wait_an(8'hFD, "t2_slot1_AN");
    chk("t2_slot1_SEG", seg, 7'h79);
    chk("t2_slot1_DP", dp, 1);

    // 3: brightness levels
    for (int t = 0; t < 3; t++) begin
      wait_ft("t3_sync");
      bright = 3'(bv[t]);
      wait_ft("t3_tick");
      on_n = 0; first = -1;
      for (int off = 1; off < SLOT; off++) begin
        @(negedge clk);
        if (an[0] === 1'b0) begin
          on_n++;
          if (first < 0) first = off;
        end
      end
      chk("t3_on_cycles", on_n, ev[t]);
      chk("t3_on_start", first, 2);
    end

    // 4: uncommitted rewrite, then COMMIT on the FRAME_TICK cycle
    bright = 3'd7;
    wr(3'd0, 6'h25);
    wait_ft("t4_sync");
    wait_an(8'hFE, "t4_nocommit_AN");
    chk("t4_nocommit_SEG", seg, 7'h08);
    wait_ft("t4_tick");
    pulse_commit();
    chk("t4_pending", cp, 1);
    wait_an(8'hFE, "t4_same_frame_AN");
    chk("t4_same_frame_SEG", seg, 7'h08);
    wait_ft("t4_next_tick");
    chk("t4_pending_cleared", cp, 0);
    wait_an(8'hFE, "t4_new_AN");
    chk("t4_new_SEG", seg, 7'h12);

    // 4b: merged commits, COMMIT and write landing on the copy edge
    pulse_commit();
    pulse_commit();
    chk("t4b_merged", cp, 1);
    wait_pos(FRAME - 1, "t4b_pos");
    commit = 1'b1; wr_en = 1'b1; wr_addr = 3'd2; wr_data = 6'h27;
    @(negedge clk);
    commit = 1'b0; wr_en = 1'b0;
    chk("t4b_tick", ft, 1);
    chk("t4b_pending_kept", cp, 1);
    n = 0;
    for (int i = 0; i < 3 * SLOT - 1; i++) begin
      @(negedge clk);
      if (an === 8'hFB) n++;
    end
    chk("t4b_late_write_excluded", n, 0);
    wait_ft("t4b_next_tick");
    chk("t4b_pending_cleared", cp, 0);
    wait_an(8'hFB, "t4b_slot2_AN");
    chk("t4b_slot2_SEG", seg, 7'h78);
    chk("t4b_slot2_DP", dp, 1);

    // 5: reset during the ON phase
    wait_an(8'hFE, "t5_on_phase");
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_AN", an, 8'hFF);
    chk("t5_async_SEG", seg, 7'h7F);
    chk("t5_async_DP", dp, 1);
    chk("t5_async_PEND", cp, 0);
    chk("t5_async_TICK", ft, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_first_tick", ft, 1);
    lit_n = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (an !== 8'hFF) lit_n++;
    end
    chk("t5_dark", lit_n, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
